// File: rtl/hpf_ctrl_pkg.sv
// hpf_ctrl_pkg
// Shared types and constants for the HPF coefficient sequencer:
//   - seq_state_t   : sequencer FSM states
//   - NUM_PRESETS   : number of cutoff presets held in the coefficient table
//   - PRESET_*      : preset index constants (cutoff frequency per index)
//   - COEF_W        : coefficient word width
//   - preset_valid(): true when an index addresses a real table row
package hpf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FRST   = 3'd2,
    ST_LOAD0  = 3'd3,
    ST_LOAD1  = 3'd4,
    ST_LOAD2  = 3'd5,
    ST_SETTLE = 3'd6,
    ST_RUN    = 3'd7
  } seq_state_t;

  localparam int NUM_PRESETS = 5;
  localparam int COEF_W      = 32;

  localparam logic [2:0] PRESET_80K  = 3'd0;
  localparam logic [2:0] PRESET_250K = 3'd1;
  localparam logic [2:0] PRESET_500K = 3'd2;
  localparam logic [2:0] PRESET_1M25 = 3'd3;
  localparam logic [2:0] PRESET_2M4  = 3'd4;

  // Coefficient slot addresses on the filter bank register-select port.
  localparam logic [1:0] SLOT_B0 = 2'd0;
  localparam logic [1:0] SLOT_B1 = 2'd1;
  localparam logic [1:0] SLOT_A1 = 2'd2;

  function automatic logic preset_valid(input logic [2:0] idx);
    return int'(idx) < NUM_PRESETS;
  endfunction

endpackage

// File: rtl/hpf_coef_rom.sv
// hpf_coef_rom
// Combinational coefficient table for the five HPF cutoff presets.
// Ports:
//   preset  in  3       preset index (0..4 valid, 5..7 return 0)
//   slot    in  2       coefficient slot: 0=b0, 1=b1, 2=a1 (3 returns 0)
//   coef    out COEF_W  signed coefficient word
module hpf_coef_rom
  import hpf_ctrl_pkg::*;
(
  input  logic [2:0]        preset,
  input  logic [1:0]        slot,
  output logic [COEF_W-1:0] coef
);

  always_comb begin
    coef = '0;
    case (preset)
      PRESET_80K: begin
        case (slot)
          SLOT_B0: coef = 32'h0000FF00;
          SLOT_B1: coef = 32'hFFFF0100;
          SLOT_A1: coef = 32'h0000FE07;
          default: coef = '0;
        endcase
      end
      PRESET_250K: begin
        case (slot)
          SLOT_B0: coef = 32'h0000FCF4;
          SLOT_B1: coef = 32'hFFFF030C;
          SLOT_A1: coef = 32'h0000F9E1;
          default: coef = '0;
        endcase
      end
      PRESET_500K: begin
        case (slot)
          SLOT_B0: coef = 32'h0000F9F5;
          SLOT_B1: coef = 32'hFFFF060B;
          SLOT_A1: coef = 32'h0000F3EA;
          default: coef = '0;
        endcase
      end
      PRESET_1M25: begin
        case (slot)
          SLOT_B0: coef = 32'h0000F168;
          SLOT_B1: coef = 32'hFFFF0E98;
          SLOT_A1: coef = 32'h0000E2CA;
          default: coef = '0;
        endcase
      end
      PRESET_2M4: begin
        case (slot)
          SLOT_B0: coef = 32'h0000E546;
          SLOT_B1: coef = 32'hFFFF1ABA;
          SLOT_A1: coef = 32'h0000CA92;
          default: coef = '0;
        endcase
      end
      default: coef = '0;
    endcase
  end

endmodule

// File: rtl/hpf_coef_sequencer.sv
// hpf_coef_sequencer
// Resets the HPF filter bank, writes the three IIR coefficients of the
// selected preset through the bank's register-select port, waits a settle
// interval and then enables the datapath (gated by the trigger-path enable).
// Ports:
//   clk                     in   system clock
//   reset_n                 in   asynchronous active-low reset
//   en                      in   datapath enable from the trigger path
//   cfg_req / cfg_preset    in   host configuration request and preset index
//   cfg_ready               out  request accepted when cfg_req && cfg_ready
//   cfg_ack                 out  one-cycle pulse on first RUN cycle after a load
//   cfg_err                 out  one-cycle pulse when an invalid index is accepted
//   busy                    out  high from acceptance until RUN
//   active_preset           out  preset currently loaded
//   filt_reset              out  synchronous reset to the filter bank
//   filt_enable_reg_select  out  coefficient write strobe
//   filt_reg_select         out  coefficient slot (0=b0, 1=b1, 2=a1)
//   filt_coefficient        out  coefficient data
//   filt_en                 out  datapath enable to the bank
module hpf_coef_sequencer
  import hpf_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEFAULT_PRESET = 0,
  parameter int AUTO_START     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              cfg_req,
  input  logic [2:0]        cfg_preset,
  output logic              cfg_ready,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              busy,
  output logic [2:0]        active_preset,
  output logic              filt_reset,
  output logic              filt_enable_reg_select,
  output logic [1:0]        filt_reg_select,
  output logic [COEF_W-1:0] filt_coefficient,
  output logic              filt_en
);

  localparam logic [2:0] DEFAULT_IDX = 3'(DEFAULT_PRESET);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  seq_state_t        state_reg, state_next;
  logic [2:0]        preset_reg, preset_next;
  logic [7:0]        settle_cnt_reg, settle_cnt_next;

  logic              filt_reset_reg, filt_reset_next;
  logic              filt_we_reg, filt_we_next;
  logic [1:0]        filt_sel_reg, filt_sel_next;
  logic [COEF_W-1:0] filt_coef_reg, filt_coef_next;
  logic              busy_reg, busy_next;
  logic              cfg_ack_reg, cfg_ack_next;
  logic              cfg_err_reg, cfg_err_next;
  logic [2:0]        active_preset_reg, active_preset_next;

  logic [COEF_W-1:0] rom_coef;
  logic              accept;

  // Ready and the datapath enable are decoded straight from the state
  // register so that a reload drops filt_en on the very next cycle and en
  // reaches the bank with no added latency.
  assign cfg_ready = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
  assign accept    = cfg_req && cfg_ready;
  assign filt_en   = (state_reg == ST_RUN) && en;

  // Next-state logic.
  always_comb begin
    state_next      = state_reg;
    preset_next     = preset_reg;
    settle_cnt_next = settle_cnt_reg;
    cfg_err_next    = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        // preset_reg already holds the default preset out of reset.
        state_next = (AUTO_START != 0) ? ST_FRST : ST_IDLE;
      end
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          if (preset_valid(cfg_preset)) begin
            state_next  = ST_FRST;
            preset_next = cfg_preset;
          end else begin
            // Invalid index: report it and stay put.
            cfg_err_next = 1'b1;
          end
        end
      end
      ST_FRST:  state_next = ST_LOAD0;
      ST_LOAD0: state_next = ST_LOAD1;
      ST_LOAD1: state_next = ST_LOAD2;
      ST_LOAD2: begin
        state_next      = ST_SETTLE;
        settle_cnt_next = '0;
      end
      ST_SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = ST_RUN;
        end else begin
          settle_cnt_next = settle_cnt_reg + 8'd1;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Registered outputs are computed from the upcoming state so that they
  // line up cycle-for-cycle with the state they describe.
  always_comb begin
    filt_reset_next    = (state_next == ST_BOOT) || (state_next == ST_IDLE) ||
                         (state_next == ST_FRST);
    filt_we_next       = (state_next == ST_LOAD0) || (state_next == ST_LOAD1) ||
                         (state_next == ST_LOAD2);
    busy_next          = filt_we_next || (state_next == ST_FRST) ||
                         (state_next == ST_SETTLE);
    cfg_ack_next       = (state_reg == ST_SETTLE) && (state_next == ST_RUN);
    active_preset_next = cfg_ack_next ? preset_reg : active_preset_reg;

    filt_sel_next = SLOT_B0;
    if (state_next == ST_LOAD1) begin
      filt_sel_next = SLOT_B1;
    end else if (state_next == ST_LOAD2) begin
      filt_sel_next = SLOT_A1;
    end

    filt_coef_next = filt_we_next ? rom_coef : '0;
  end

  hpf_coef_rom u_rom (
    .preset (preset_next),
    .slot   (filt_sel_next),
    .coef   (rom_coef)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_BOOT;
      preset_reg        <= DEFAULT_IDX;
      settle_cnt_reg    <= '0;
      filt_reset_reg    <= 1'b1;
      filt_we_reg       <= 1'b0;
      filt_sel_reg      <= '0;
      filt_coef_reg     <= '0;
      busy_reg          <= 1'b0;
      cfg_ack_reg       <= 1'b0;
      cfg_err_reg       <= 1'b0;
      active_preset_reg <= DEFAULT_IDX;
    end else begin
      state_reg         <= state_next;
      preset_reg        <= preset_next;
      settle_cnt_reg    <= settle_cnt_next;
      filt_reset_reg    <= filt_reset_next;
      filt_we_reg       <= filt_we_next;
      filt_sel_reg      <= filt_sel_next;
      filt_coef_reg     <= filt_coef_next;
      busy_reg          <= busy_next;
      cfg_ack_reg       <= cfg_ack_next;
      cfg_err_reg       <= cfg_err_next;
      active_preset_reg <= active_preset_next;
    end
  end

  assign filt_reset             = filt_reset_reg;
  assign filt_enable_reg_select = filt_we_reg;
  assign filt_reg_select        = filt_sel_reg;
  assign filt_coefficient       = filt_coef_reg;
  assign busy                   = busy_reg;
  assign cfg_ack                = cfg_ack_reg;
  assign cfg_err                = cfg_err_reg;
  assign active_preset          = active_preset_reg;

endmodule

// File: tb/tb_hpf_coef_sequencer.sv
// tb_hpf_coef_sequencer
// Directed bench for hpf_coef_sequencer with SETTLE_CYCLES = 4,
// DEFAULT_PRESET = 0, AUTO_START = 1. Outputs are sampled just after the
// falling edge; inputs change on the falling edge.
module tb_hpf_coef_sequencer;

  localparam int SETTLE = 4;
  localparam int RUN_K  = 5 + SETTLE;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        cfg_req;
  logic [2:0]  cfg_preset;
  logic        cfg_ready;
  logic        cfg_ack;
  logic        cfg_err;
  logic        busy;
  logic [2:0]  active_preset;
  logic        filt_reset;
  logic        filt_enable_reg_select;
  logic [1:0]  filt_reg_select;
  logic [31:0] filt_coefficient;
  logic        filt_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] coef_tab [0:4][0:2];

  always #5 clk = ~clk;

  hpf_coef_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .DEFAULT_PRESET (0),
    .AUTO_START     (1)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .en                     (en),
    .cfg_req                (cfg_req),
    .cfg_preset             (cfg_preset),
    .cfg_ready              (cfg_ready),
    .cfg_ack                (cfg_ack),
    .cfg_err                (cfg_err),
    .busy                   (busy),
    .active_preset          (active_preset),
    .filt_reset             (filt_reset),
    .filt_enable_reg_select (filt_enable_reg_select),
    .filt_reg_select        (filt_reg_select),
    .filt_coefficient       (filt_coefficient),
    .filt_en                (filt_en)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Follows one load sequence whose accepting edge has just occurred (or is
  // the next edge after reset release). Checks every cycle k = 1..RUN_K.
  // When nxt >= 0 a new request for preset nxt is raised during SETTLE and
  // held, to be accepted on the first RUN cycle.
  task automatic do_load(input int p, input int nxt);
    for (int k = 1; k <= RUN_K; k++) begin
      @(negedge clk);
      if (k == 1) cfg_req = 1'b0;
      en = (k == 1) || (k == 3) || (k == 6) || (k == RUN_K);
      #1;
      if (k == 1) begin
        check_val("frst_reset", 32'(filt_reset), 1);
        check_val("frst_busy", 32'(busy), 1);
        check_val("frst_we", 32'(filt_enable_reg_select), 0);
        check_val("frst_en", 32'(filt_en), 0);
        check_val("frst_ready", 32'(cfg_ready), 0);
      end else if (k <= 4) begin
        check_val("load_we", 32'(filt_enable_reg_select), 1);
        check_val("load_sel", 32'(filt_reg_select), k - 2);
        check_val("load_coef", filt_coefficient, coef_tab[p][k-2]);
        check_val("load_reset", 32'(filt_reset), 0);
        check_val("load_en", 32'(filt_en), 0);
      end else if (k < RUN_K) begin
        check_val("settle_we", 32'(filt_enable_reg_select), 0);
        check_val("settle_coef", filt_coefficient, 0);
        check_val("settle_busy", 32'(busy), 1);
        check_val("settle_en", 32'(filt_en), 0);
        check_val("settle_ack", 32'(cfg_ack), 0);
        if (k == 6 && nxt >= 0) begin
          cfg_req    = 1'b1;
          cfg_preset = 3'(nxt);
        end
      end else begin
        check_val("run_ack", 32'(cfg_ack), 1);
        check_val("run_busy", 32'(busy), 0);
        check_val("run_ready", 32'(cfg_ready), 1);
        check_val("run_active", 32'(active_preset), p);
        check_val("run_en_hi", 32'(filt_en), 1);
        en = 1'b0;
        #1;
        check_val("run_en_lo", 32'(filt_en), 0);
        en = 1'b1;
      end
    end
    $display("load preset %0d sequence checked through first RUN cycle", p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    coef_tab[0][0] = 32'h0000FF00; coef_tab[0][1] = 32'hFFFF0100; coef_tab[0][2] = 32'h0000FE07;
    coef_tab[1][0] = 32'h0000FCF4; coef_tab[1][1] = 32'hFFFF030C; coef_tab[1][2] = 32'h0000F9E1;
    coef_tab[2][0] = 32'h0000F9F5; coef_tab[2][1] = 32'hFFFF060B; coef_tab[2][2] = 32'h0000F3EA;
    coef_tab[3][0] = 32'h0000F168; coef_tab[3][1] = 32'hFFFF0E98; coef_tab[3][2] = 32'h0000E2CA;
    coef_tab[4][0] = 32'h0000E546; coef_tab[4][1] = 32'hFFFF1ABA; coef_tab[4][2] = 32'h0000CA92;

    reset_n    = 1'b0;
    en         = 1'b1;
    cfg_req    = 1'b0;
    cfg_preset = 3'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_filt_reset", 32'(filt_reset), 1);
    check_val("rst_we", 32'(filt_enable_reg_select), 0);
    check_val("rst_sel", 32'(filt_reg_select), 0);
    check_val("rst_coef", filt_coefficient, 0);
    check_val("rst_filt_en", 32'(filt_en), 0);
    check_val("rst_ready", 32'(cfg_ready), 0);
    check_val("rst_ack", 32'(cfg_ack), 0);
    check_val("rst_err", 32'(cfg_err), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_active", 32'(active_preset), 0);
    $display("reset state checked");

    // Auto-start load of the default preset.
    @(negedge clk);
    reset_n = 1'b1;
    do_load(0, -1);

    // Reload from RUN with preset 4.
    cfg_req    = 1'b1;
    cfg_preset = 3'd4;
    do_load(4, -1);

    // Invalid preset in RUN: error pulse only.
    cfg_req    = 1'b1;
    cfg_preset = 3'd6;
    @(negedge clk);
    cfg_req = 1'b0;
    #1;
    check_val("inv_err", 32'(cfg_err), 1);
    check_val("inv_ready", 32'(cfg_ready), 1);
    check_val("inv_filt_en", 32'(filt_en), 1);
    check_val("inv_we", 32'(filt_enable_reg_select), 0);
    check_val("inv_busy", 32'(busy), 0);
    check_val("inv_reset", 32'(filt_reset), 0);
    check_val("inv_ack", 32'(cfg_ack), 0);
    check_val("inv_active", 32'(active_preset), 4);
    @(negedge clk);
    #1;
    check_val("inv_err_end", 32'(cfg_err), 0);
    check_val("inv_filt_en2", 32'(filt_en), 1);
    check_val("inv_we2", 32'(filt_enable_reg_select), 0);
    $display("invalid preset 6 request checked");

    // Load preset 1; a request for preset 3 raised during SETTLE is held
    // and must be taken on the first RUN cycle, giving exactly one reload.
    cfg_req    = 1'b1;
    cfg_preset = 3'd1;
    do_load(1, 3);
    do_load(3, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("post_busy", 32'(busy), 0);
      check_val("post_reset", 32'(filt_reset), 0);
      check_val("post_we", 32'(filt_enable_reg_select), 0);
      check_val("post_active", 32'(active_preset), 3);
    end
    $display("held request produced a single reload");

    // Reset asserted during SETTLE of a preset-1 load.
    cfg_req    = 1'b1;
    cfg_preset = 3'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) cfg_req = 1'b0;
    end
    #2;
    check_val("pre_abort_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_val("abort_reset", 32'(filt_reset), 1);
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_we", 32'(filt_enable_reg_select), 0);
    check_val("abort_coef", filt_coefficient, 0);
    check_val("abort_ready", 32'(cfg_ready), 0);
    check_val("abort_filt_en", 32'(filt_en), 0);
    check_val("abort_active", 32'(active_preset), 0);
    $display("asynchronous reset during SETTLE checked");
    @(negedge clk);
    reset_n = 1'b1;
    do_load(0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpf_coef_sequencer.md
# hpf_coef_sequencer

Configuration and run-time sequencer for the HPF pedestal-recovery filter bank. It holds a table of five HPF cutoff presets. On power-up, or on a host request, it resets the filter bank and loads the three IIR coefficients for the selected preset through the bank's register-select port. After a settle interval it enables the datapath, gated by the trigger-path enable. It sits between the host/slow-control register file and the 40 filter instances, replacing their hard-wired configuration.

## Interface
Parameters:
- SETTLE_CYCLES, 16: cycles between the last coefficient write and RUN (1..255).
- DEFAULT_PRESET, 0: preset loaded after reset (0..4).
- AUTO_START, 1: 1 = load DEFAULT_PRESET automatically after reset; 0 = wait in IDLE.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  datapath enable from the trigger path.
- cfg_req  in  1  configuration request (valid).
- cfg_preset  in  3  preset index with cfg_req: 0=80 kHz, 1=250 kHz, 2=500 kHz, 3=1.25 MHz, 4=2.4 MHz.
- cfg_ready  out  1  request is accepted when cfg_req && cfg_ready.
- cfg_ack  out  1  one-cycle pulse on the first RUN cycle after a load.
- cfg_err  out  1  one-cycle pulse when an invalid index (5..7) is accepted.
- busy  out  1  high from request acceptance until RUN.
- active_preset  out  3  preset currently loaded.
- filt_reset  out  1  synchronous active-high reset to the filter bank.
- filt_enable_reg_select  out  1  coefficient write strobe.
- filt_reg_select  out  2  coefficient slot: 0=b0, 1=b1, 2=a1.
- filt_coefficient  out  32  coefficient data, signed.
- filt_en  out  1  datapath enable to the bank.

## Operation
- States: BOOT, IDLE, FRST, LOAD0, LOAD1, LOAD2, SETTLE, RUN.
- BOOT: the state held during reset.
  - Goes to FRST with DEFAULT_PRESET if AUTO_START = 1.
  - Goes to IDLE otherwise.
- IDLE and RUN are the only states with cfg_ready = 1.
- Accepted valid index: latch the preset and go to FRST.
- Accepted invalid index: pulse cfg_err, no state or preset change, busy stays low.
- FRST: filt_reset = 1 for one cycle.
- LOAD0, LOAD1, LOAD2: filt_enable_reg_select = 1 with reg_select 0, 1, 2 respectively, and the table coefficient on filt_coefficient.
- SETTLE: count SETTLE_CYCLES, then go to RUN.
- RUN: on entry, update active_preset and pulse cfg_ack.
- filt_reset is 1 in BOOT, IDLE and FRST; 0 in all other states.
- filt_en = (state == RUN) && en. This path is combinational and is the only one; filt_en is never 1 in any other state.
- Coefficient table (c0 / c1 / c2, hex):
  - 80 kHz: 0000FF00 / FFFF0100 / 0000FE07
  - 250 kHz: 0000FCF4 / FFFF030C / 0000F9E1
  - 500 kHz: 0000F9F5 / FFFF060B / 0000F3EA
  - 1.25 MHz: 0000F168 / FFFF0E98 / 0000E2CA
  - 2.4 MHz: 0000E546 / FFFF1ABA / 0000CA92
- Outside the LOAD states: filt_coefficient = 0 and filt_reg_select = 0.
- Boundary conditions:
  - en toggling during a load: ignored; the sequence completes.
  - Request while busy: not accepted. The requester holds cfg_req until cfg_ready.
  - Request in RUN: a reload. filt_en drops on the following cycle.
  - reset_n asserted mid-sequence: immediate return to reset values; active_preset reverts to DEFAULT_PRESET.
  - Illegal state encoding: go to BOOT.

## Timing
- Reset values:
  - filt_reset = 1
  - all other filt_* outputs = 0
  - cfg_ready = 0, cfg_ack = 0, cfg_err = 0, busy = 0
  - active_preset = DEFAULT_PRESET
- All outputs are registered except filt_en and cfg_ready.
- Load sequence, with the request accepted on edge T:
  - T+1: FRST (busy = 1 from here until RUN)
  - T+2: LOAD0
  - T+3: LOAD1
  - T+4: LOAD2
  - T+5 .. T+4+SETTLE_CYCLES: SETTLE
  - T+5+SETTLE_CYCLES: RUN, with cfg_ack.
- Auto-start: the first edge after reset_n rises counts as T.
- cfg_err appears at T+1.

## Structure
- Package hpf_ctrl_pkg holds:
  - the state enum;
  - NUM_PRESETS = 5;
  - preset index constants;
  - COEF_W = 32.
- Sub-module hpf_coef_rom: combinational (preset, slot) -> 32-bit coefficient table; index ≥ 5 returns 0.
- The sequencer FSM and settle counter live in the top module.

## Test plan
- AUTO_START = 1, SETTLE_CYCLES = 4, release reset:
  - LOAD0..2 at cycles 2..4 write 0000FF00, FFFF0100, 0000FE07 in slots 0, 1, 2;
  - cfg_ack at cycle 9.
- In RUN, request preset 4:
  - filt_reset pulses;
  - coefficients 0000E546, FFFF1ABA, 0000CA92 are written;
  - active_preset = 4 after cfg_ack.
- Request preset 6 in RUN: cfg_err pulses one cycle; no writes; filt_en unaffected.
- Toggle en during LOAD1 and SETTLE: filt_en stays 0 until RUN, then follows en with zero latency.
- Request held high during busy: accepted only in the first RUN cycle; exactly one reload.
- Assert reset_n low during SETTLE: all outputs take reset values asynchronously; the sequence restarts with DEFAULT_PRESET.
